// File: rtl/conv_router_pkg.sv
// Shared defaults, FSM state type and window index helpers for the conv
// weight/pixel router.
package conv_router_pkg;

    localparam int unsigned DEF_NUM_FILT     = 6;
    localparam int unsigned DEF_FILT_INST    = 4;
    localparam int unsigned DEF_FILT_K       = 5;
    localparam int unsigned DEF_PXL_WIDTH    = 8;
    localparam int unsigned DEF_WEIGHT_WIDTH = 8;
    localparam int unsigned DEF_NUM_PXL_ROW  = 8;
    localparam int unsigned DEF_STRIDE       = 1;
    localparam int unsigned DEF_CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_RUN,
        ST_PEND
    } router_state_t;

    // Flat pixel index (row-major over the input rows) feeding window i, element (r,c).
    function automatic int unsigned win_pxl_idx(input int unsigned r,
                                                input int unsigned c,
                                                input int unsigned i,
                                                input int unsigned stride,
                                                input int unsigned row_len);
        return r * row_len + i * stride + c;
    endfunction

    function automatic int unsigned win_elem_idx(input int unsigned r,
                                                 input int unsigned c,
                                                 input int unsigned k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/conv_wght_bank.sv
// Double-buffered weight bank: beats fill the shadow half, swap_i flips which
// half is presented as the active bank.
module conv_wght_bank
    import conv_router_pkg::*;
#(
    parameter int unsigned NUM_FILT     = DEF_NUM_FILT,
    parameter int unsigned FILT_K       = DEF_FILT_K,
    parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
    input  logic                                                           clk_i,
    input  logic                                                           rst_i,
    input  logic                                                           wr_en_i,
    input  logic [FILT_K*WEIGHT_WIDTH-1:0]                                 wght_data_i,
    input  logic                                                           swap_i,
    output logic                                                           last_beat_o,
    output logic [NUM_FILT-1:0][FILT_K*FILT_K-1:0][WEIGHT_WIDTH-1:0]       active_o
);

    localparam int unsigned NUM_BEATS = NUM_FILT * FILT_K;
    localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    logic [BEAT_W-1:0]                                             beat_cnt_q;
    logic                                                          bank_sel_q;
    logic [1:0][NUM_FILT-1:0][FILT_K*FILT_K-1:0][WEIGHT_WIDTH-1:0] bank_q;

    assign last_beat_o = (beat_cnt_q == BEAT_W'(NUM_BEATS - 1));
    assign active_o    = bank_q[bank_sel_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q <= '0;
            bank_sel_q <= 1'b0;
            bank_q     <= '0;
        end else begin
            if (swap_i)
                bank_sel_q <= ~bank_sel_q;
            if (wr_en_i) begin
                beat_cnt_q <= last_beat_o ? '0 : beat_cnt_q + BEAT_W'(1);
                // Beat number decodes to (filter, row); only the shadow half is written.
                for (int unsigned f = 0; f < NUM_FILT; f++) begin
                    for (int unsigned r = 0; r < FILT_K; r++) begin
                        if (beat_cnt_q == BEAT_W'(f * FILT_K + r)) begin
                            for (int unsigned c = 0; c < FILT_K; c++)
                                bank_q[~bank_sel_q][f][win_elem_idx(r, c, FILT_K)]
                                    <= wght_data_i[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_wght_pxl_router.sv
// Routes pixel blocks into strided windows replicated per filter and pairs
// them with the active weight bank behind a valid/ready output register.
module conv_wght_pxl_router
    import conv_router_pkg::*;
#(
    parameter int unsigned NUM_FILT     = DEF_NUM_FILT,
    parameter int unsigned FILT_INST    = DEF_FILT_INST,
    parameter int unsigned FILT_K       = DEF_FILT_K,
    parameter int unsigned PXL_WIDTH    = DEF_PXL_WIDTH,
    parameter int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int unsigned NUM_PXL_ROW  = DEF_NUM_PXL_ROW,
    parameter int unsigned STRIDE       = DEF_STRIDE,
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                                                                   clk_i,
    input  logic                                                                   rst_i,
    input  logic                                                                   wght_valid_i,
    output logic                                                                   wght_ready_o,
    input  logic [FILT_K*WEIGHT_WIDTH-1:0]                                         wght_data_i,
    input  logic                                                                   pxl_valid_i,
    output logic                                                                   pxl_ready_o,
    input  logic [FILT_K-1:0][NUM_PXL_ROW-1:0][PXL_WIDTH-1:0]                      pxl_rows_i,
    output logic                                                                   out_valid_o,
    input  logic                                                                   out_ready_i,
    output logic [NUM_FILT-1:0][FILT_INST-1:0][FILT_K*FILT_K-1:0][PXL_WIDTH-1:0]    pxl_win_o,
    output logic [NUM_FILT-1:0][FILT_INST-1:0][FILT_K*FILT_K-1:0][WEIGHT_WIDTH-1:0] wght_o,
    output logic                                                                   wght_loaded_o,
    output logic [CNT_WIDTH-1:0]                                                   win_cnt_o
);

    localparam int unsigned KK = FILT_K * FILT_K;

    if ((FILT_INST - 1) * STRIDE + FILT_K > NUM_PXL_ROW) begin : g_bad_geometry
        $error("conv_wght_pxl_router: windows exceed NUM_PXL_ROW");
    end

    router_state_t state_q, state_d;

    logic wght_rdy, pxl_rdy, swap;
    logic wght_acc, pxl_acc, out_hs, out_free;
    logic last_beat;
    logic out_valid_q, loaded_q;
    logic [CNT_WIDTH-1:0] win_cnt_q;

    logic [FILT_K*NUM_PXL_ROW-1:0][PXL_WIDTH-1:0]                  pxl_flat;
    logic [NUM_FILT-1:0][FILT_INST-1:0][KK-1:0][PXL_WIDTH-1:0]     win_d, win_q;
    logic [NUM_FILT-1:0][KK-1:0][WEIGHT_WIDTH-1:0]                 bank_active;

    assign out_free = !out_valid_q || out_ready_i;
    assign out_hs   = out_valid_q && out_ready_i;
    assign wght_acc = wght_valid_i && wght_rdy;
    assign pxl_acc  = pxl_valid_i && pxl_rdy;

    conv_wght_bank #(
        .NUM_FILT     (NUM_FILT),
        .FILT_K       (FILT_K),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_bank (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wght_acc),
        .wght_data_i (wght_data_i),
        .swap_i      (swap),
        .last_beat_o (last_beat),
        .active_o    (bank_active)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY, ST_RUN: if (wght_acc && last_beat) state_d = ST_PEND;
            ST_PEND:          if (out_free) state_d = ST_RUN;
            default:          state_d = ST_EMPTY;
        endcase
    end

    // The swap waits for a free output slot so a held block keeps its weights.
    always_comb begin
        wght_rdy = 1'b0;
        pxl_rdy  = 1'b0;
        swap     = 1'b0;
        case (state_q)
            ST_EMPTY: wght_rdy = 1'b1;
            ST_RUN: begin
                wght_rdy = 1'b1;
                pxl_rdy  = out_free;
            end
            ST_PEND:  swap = out_free;
            default:  ;
        endcase
    end

    assign pxl_flat = pxl_rows_i;

    always_comb begin
        win_d = '0;
        for (int unsigned f = 0; f < NUM_FILT; f++)
            for (int unsigned i = 0; i < FILT_INST; i++)
                for (int unsigned r = 0; r < FILT_K; r++)
                    for (int unsigned c = 0; c < FILT_K; c++)
                        win_d[f][i][win_elem_idx(r, c, FILT_K)] =
                            pxl_flat[win_pxl_idx(r, c, i, STRIDE, NUM_PXL_ROW)];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            win_q       <= '0;
            win_cnt_q   <= '0;
            loaded_q    <= 1'b0;
        end else begin
            if (swap)
                loaded_q <= 1'b1;
            if (out_hs)
                win_cnt_q <= win_cnt_q + CNT_WIDTH'(1);
            if (pxl_acc) begin
                out_valid_q <= 1'b1;
                win_q       <= win_d;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        wght_o = '0;
        for (int unsigned f = 0; f < NUM_FILT; f++)
            for (int unsigned i = 0; i < FILT_INST; i++)
                wght_o[f][i] = bank_active[f];
    end

    assign wght_ready_o  = wght_rdy;
    assign pxl_ready_o   = pxl_rdy;
    assign out_valid_o   = out_valid_q;
    assign pxl_win_o     = win_q;
    assign wght_loaded_o = loaded_q;
    assign win_cnt_o     = win_cnt_q;

endmodule

// File: tb/tb_conv_wght_pxl_router.sv
// Bench for conv_wght_pxl_router: directed scenarios plus random traffic,
// checked against a cycle-level reference model; a second instance uses stride 2.
module tb_conv_wght_pxl_router;

    localparam int unsigned NF   = 6;
    localparam int unsigned FI   = 4;
    localparam int unsigned K    = 5;
    localparam int unsigned KK   = K * K;
    localparam int unsigned PW   = 8;
    localparam int unsigned WW   = 8;
    localparam int unsigned NPR  = 8;
    localparam int unsigned S    = 1;
    localparam int unsigned NPR2 = 12;
    localparam int unsigned S2   = 2;
    localparam int unsigned CW   = 16;
    localparam int unsigned NB   = NF * K;
    localparam int unsigned CHW  = 256;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic wght_valid_i, pxl_valid_i, out_ready_i;
    logic [K*WW-1:0] wght_data_i;
    logic [K-1:0][NPR-1:0][PW-1:0]  rows1;
    logic [K-1:0][NPR2-1:0][PW-1:0] rows2;

    logic wght_ready_o, pxl_ready_o, out_valid_o, wght_loaded_o;
    logic [NF-1:0][FI-1:0][KK-1:0][PW-1:0] win1;
    logic [NF-1:0][FI-1:0][KK-1:0][WW-1:0] wo1;
    logic [CW-1:0] win_cnt_o;

    logic wght_ready2, pxl_ready2, out_valid2, wght_loaded2;
    logic [NF-1:0][FI-1:0][KK-1:0][PW-1:0] win2;
    logic [NF-1:0][FI-1:0][KK-1:0][WW-1:0] wo2;
    logic [CW-1:0] win_cnt2;

    // Reference model
    int unsigned m_beats;
    logic        m_loaded, m_valid;
    logic [NF-1:0][KK-1:0][WW-1:0]         m_sh, m_act;
    logic [NF-1:0][FI-1:0][KK-1:0][PW-1:0] m_win1, m_win2;
    logic [CW-1:0] m_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    conv_wght_pxl_router #(
        .NUM_FILT(NF), .FILT_INST(FI), .FILT_K(K), .PXL_WIDTH(PW), .WEIGHT_WIDTH(WW),
        .NUM_PXL_ROW(NPR), .STRIDE(S), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wght_valid_i(wght_valid_i), .wght_ready_o(wght_ready_o), .wght_data_i(wght_data_i),
        .pxl_valid_i(pxl_valid_i), .pxl_ready_o(pxl_ready_o), .pxl_rows_i(rows1),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pxl_win_o(win1), .wght_o(wo1), .wght_loaded_o(wght_loaded_o), .win_cnt_o(win_cnt_o)
    );

    conv_wght_pxl_router #(
        .NUM_FILT(NF), .FILT_INST(FI), .FILT_K(K), .PXL_WIDTH(PW), .WEIGHT_WIDTH(WW),
        .NUM_PXL_ROW(NPR2), .STRIDE(S2), .CNT_WIDTH(CW)
    ) dut_s2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .wght_valid_i(wght_valid_i), .wght_ready_o(wght_ready2), .wght_data_i(wght_data_i),
        .pxl_valid_i(pxl_valid_i), .pxl_ready_o(pxl_ready2), .pxl_rows_i(rows2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready_i),
        .pxl_win_o(win2), .wght_o(wo2), .wght_loaded_o(wght_loaded2), .win_cnt_o(win_cnt2)
    );

    task automatic check(input string tag, input logic [CHW-1:0] obs, input logic [CHW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [K*WW-1:0] wbeat(input int b, input int mul, input int add);
        logic [K*WW-1:0] v;
        for (int c = 0; c < K; c++) v[c*WW +: WW] = WW'(b * mul + c + add);
        return v;
    endfunction

    task automatic reset_model();
        m_beats  = 0;
        m_loaded = 1'b0;
        m_valid  = 1'b0;
        m_sh     = '0;
        m_act    = '0;
        m_win1   = '0;
        m_win2   = '0;
        m_cnt    = '0;
    endtask

    task automatic set_idle();
        wght_valid_i = 1'b0;
        wght_data_i  = '0;
        pxl_valid_i  = 1'b0;
        out_ready_i  = 1'b0;
    endtask

    task automatic compare_all();
        logic pend, free;
        pend = (m_beats == NB);
        free = !m_valid || out_ready_i;
        check("out_valid",    CHW'(out_valid_o),   CHW'(m_valid));
        check("wght_ready",   CHW'(wght_ready_o),  CHW'(!pend));
        check("pxl_ready",    CHW'(pxl_ready_o),   CHW'(m_loaded && !pend && free));
        check("wght_loaded",  CHW'(wght_loaded_o), CHW'(m_loaded));
        check("win_cnt",      CHW'(win_cnt_o),     CHW'(m_cnt));
        check("out_valid_s2", CHW'(out_valid2),    CHW'(m_valid));
        check("wght_ready_s2", CHW'(wght_ready2),  CHW'(!pend));
        check("pxl_ready_s2", CHW'(pxl_ready2),    CHW'(m_loaded && !pend && free));
        check("loaded_s2",    CHW'(wght_loaded2),  CHW'(m_loaded));
        check("win_cnt_s2",   CHW'(win_cnt2),      CHW'(m_cnt));
        for (int f = 0; f < NF; f++) begin
            for (int i = 0; i < FI; i++) begin
                check("pxl_win",    CHW'(win1[f][i]), CHW'(m_win1[f][i]));
                check("pxl_win_s2", CHW'(win2[f][i]), CHW'(m_win2[f][i]));
                check("wght_o",     CHW'(wo1[f][i]),  CHW'(m_act[f]));
                check("wght_o_s2",  CHW'(wo2[f][i]),  CHW'(m_act[f]));
            end
        end
    endtask

    // One clock: predict handshakes from the model, advance it at the edge, compare at negedge.
    task automatic step(input bit full);
        bit pend, free, wacc, pacc, sw, hs;
        pend = (m_beats == NB);
        free = !m_valid || out_ready_i;
        wacc = wght_valid_i && !pend;
        pacc = pxl_valid_i && m_loaded && !pend && free;
        sw   = pend && free;
        hs   = m_valid && out_ready_i;
        @(posedge clk_i);
        if (sw) begin
            m_act    = m_sh;
            m_loaded = 1'b1;
            m_beats  = 0;
        end
        if (wacc) begin
            for (int c = 0; c < K; c++)
                m_sh[m_beats / K][(m_beats % K) * K + c] = wght_data_i[c*WW +: WW];
            m_beats++;
        end
        if (hs) m_cnt = m_cnt + CW'(1);
        if (pacc) begin
            m_valid = 1'b1;
            for (int f = 0; f < NF; f++)
                for (int i = 0; i < FI; i++)
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++) begin
                            m_win1[f][i][r*K + c] = rows1[r][i*S + c];
                            m_win2[f][i][r*K + c] = rows2[r][i*S2 + c];
                        end
        end else if (hs) begin
            m_valid = 1'b0;
        end
        @(negedge clk_i);
        if (full) compare_all();
    endtask

    task automatic random_inputs();
        wght_valid_i = ($urandom_range(0, 1) == 1);
        for (int c = 0; c < K; c++) wght_data_i[c*WW +: WW] = WW'($urandom);
        pxl_valid_i = ($urandom_range(0, 1) == 1);
        out_ready_i = ($urandom_range(0, 3) != 0);
        for (int r = 0; r < K; r++) begin
            for (int p = 0; p < NPR; p++)  rows1[r][p] = PW'($urandom);
            for (int p = 0; p < NPR2; p++) rows2[r][p] = PW'($urandom);
        end
    endtask

    task automatic async_reset();
        rst_i = 1'b1;
        #1;
        reset_model();
        compare_all();
        check("async_rst_valid", CHW'(out_valid_o), CHW'(0));
        check("async_rst_cnt",   CHW'(win_cnt_o),   CHW'(0));
        @(posedge clk_i);
        @(negedge clk_i);
        set_idle();
        rst_i = 1'b0;
        compare_all();
    endtask

    initial begin
        set_idle();
        rows1 = '0;
        rows2 = '0;
        reset_model();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        compare_all();
        check("rst_wght_ready", CHW'(wght_ready_o), CHW'(1));
        check("rst_pxl_ready",  CHW'(pxl_ready_o),  CHW'(0));

        // First load: weight = beat*5 + column
        for (int b = 0; b < NB; b++) begin
            wght_valid_i = 1'b1;
            wght_data_i  = wbeat(b, 5, 0);
            step(1);
        end
        check("loaded_edge_n",  CHW'(wght_loaded_o), CHW'(0));
        set_idle();
        step(1);
        check("loaded_edge_n1", CHW'(wght_loaded_o), CHW'(1));
        check("pxl_ready_n1",   CHW'(pxl_ready_o),   CHW'(1));
        check("wght_2_3_7",     CHW'(wo1[2][3][7]),  CHW'(57));

        // Patterned pixel block, consumer stalled
        for (int r = 0; r < K; r++) begin
            for (int p = 0; p < NPR; p++)  rows1[r][p] = PW'(r * 16 + p);
            for (int p = 0; p < NPR2; p++) rows2[r][p] = PW'(r * 16 + p);
        end
        pxl_valid_i = 1'b1;
        step(1);
        check("blk_valid", CHW'(out_valid_o), CHW'(1));
        for (int f = 0; f < NF; f++) begin
            check("win_0_3_6",    CHW'(win1[f][3][6]), CHW'(8'h14));
            check("win_s2_3_0",   CHW'(win2[f][3][0]), CHW'(8'h06));
        end

        // Reload while output stalled
        pxl_valid_i = 1'b0;
        for (int b = 0; b < NB; b++) begin
            wght_valid_i = 1'b1;
            wght_data_i  = wbeat(b, 3, 100);
            step(1);
        end
        wght_data_i = wbeat(7, 9, 9);
        step(1);
        check("pend_pxl_ready",  CHW'(pxl_ready_o),  CHW'(0));
        check("pend_wght_ready", CHW'(wght_ready_o), CHW'(0));
        check("pend_wght_hold",  CHW'(wo1[2][3][7]), CHW'(57));
        wght_valid_i = 1'b0;
        out_ready_i  = 1'b1;
        step(1);
        check("swap_cnt",   CHW'(win_cnt_o),    CHW'(1));
        check("swap_wght",  CHW'(wo1[2][3][7]), CHW'(135));
        check("swap_valid", CHW'(out_valid_o),  CHW'(0));

        // Last weight beat and pixel block on the same edge
        for (int b = 0; b < NB - 1; b++) begin
            wght_valid_i = 1'b1;
            wght_data_i  = wbeat(b, 2, 1);
            step(1);
        end
        wght_data_i = wbeat(NB - 1, 2, 1);
        pxl_valid_i = 1'b1;
        step(1);
        check("same_edge_valid", CHW'(out_valid_o),  CHW'(1));
        check("same_edge_old",   CHW'(wo1[2][3][7]), CHW'(135));
        wght_valid_i = 1'b0;
        out_ready_i  = 1'b0;
        step(1);
        check("held_old", CHW'(wo1[2][3][7]), CHW'(135));
        out_ready_i = 1'b1;
        step(1);
        check("new_after_swap", CHW'(wo1[2][3][7]), CHW'(25));
        step(1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            random_inputs();
            step(1);
        end
        async_reset();

        // Counter wrap with continuous streaming
        for (int b = 0; b < NB; b++) begin
            wght_valid_i = 1'b1;
            wght_data_i  = wbeat(b, 1, 0);
            step(0);
        end
        set_idle();
        step(1);
        pxl_valid_i = 1'b1;
        out_ready_i = 1'b1;
        for (int n = 0; n < 65536; n++) step(0);
        compare_all();
        check("cnt_max", CHW'(win_cnt_o), CHW'(16'hFFFF));
        step(1);
        check("cnt_wrap", CHW'(win_cnt_o), CHW'(0));
        repeat (3) step(1);
        async_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_wght_pxl_router.md
# conv_wght_pxl_router

Parametrised, sequential weight/pixel router for the conv stages. It accepts a stream of filter-row weight beats into a double-buffered weight bank and accepts blocks of FILT_K pixel rows. Each pixel block is sliced into FILT_INST strided FILT_K×FILT_K windows, replicated for every filter, and presented with the active weight bank to the MAC array through a valid/ready output register. Weights can be reloaded in the background; bank swaps never disturb an output that is still being held.

## Interface
- NUM_FILT, 6, number of filters (output channels)
- FILT_INST, 4, window instances per filter per pixel block
- FILT_K, 5, filter side; window = FILT_K*FILT_K elements
- PXL_WIDTH, 8, pixel width in bits
- WEIGHT_WIDTH, 8, weight width in bits
- NUM_PXL_ROW, 8, pixels per input row; requires (FILT_INST-1)*STRIDE+FILT_K <= NUM_PXL_ROW (elaboration-time check)
- STRIDE, 1, horizontal window stride in pixels
- CNT_WIDTH, 16, width of window counter
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- wght_valid_i  in  1  weight beat valid
- wght_ready_o  out  1  weight beat accepted when both high
- wght_data_i  in  FILT_K*WEIGHT_WIDTH  one filter row; column c at [c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- pxl_valid_i  in  1  pixel block valid
- pxl_ready_o  out  1  pixel block accepted when both high
- pxl_rows_i  in  [FILT_K][NUM_PXL_ROW][PXL_WIDTH]  FILT_K input rows
- out_valid_o  out  1  output register holds a block
- out_ready_i  in  1  consumer accepts output
- pxl_win_o  out  [NUM_FILT][FILT_INST][FILT_K*FILT_K][PXL_WIDTH]  windows
- wght_o  out  [NUM_FILT][FILT_INST][FILT_K*FILT_K][WEIGHT_WIDTH]  active weights
- wght_loaded_o  out  1  an active bank is valid
- win_cnt_o  out  CNT_WIDTH  output blocks delivered, wraps

## Operation
- Weight beat b (0..NUM_FILT*FILT_K-1), counted by beat_cnt: filter f=b/FILT_K, row r=b%FILT_K; shadow[f][r*FILT_K+c] = column c.
- FSM states EMPTY (no active bank), RUN (active valid), PEND (shadow full, awaiting swap).
- EMPTY/RUN: wght_ready_o=1; accepting the last beat (b=NUM_FILT*FILT_K-1) resets beat_cnt to 0 and moves to PEND.
- PEND: wght_ready_o=0, pxl_ready_o=0; swap (bank_sel toggles) at the first edge where out_valid_o=0 or out_ready_i=1; next state RUN.
- pxl_ready_o = (state==RUN) && (!out_valid_o || out_ready_i).
- On pixel accept: pxl_win_o[f][i][r*FILT_K+c] <= pxl_rows_i[r][i*STRIDE+c] for all f; out_valid_o <= 1.
- wght_o[f][i][k] = active_bank[f][k] for all i (combinational from bank_sel); it is stable while out_valid_o=1, because swap is blocked.
- Output handshake: when out_valid_o && out_ready_i, win_cnt_o increments (wrapping at 2^CNT_WIDTH) and out_valid_o clears unless a new block is accepted on the same edge.
- A weight beat and a pixel block accepted on the same edge: the pixel block is tagged to the current active bank; shadow writes never affect the active bank.

## Timing
- Reset: state=EMPTY, beat_cnt=0, bank_sel=0, both banks=0, out_valid_o=0, pxl_win_o=0, win_cnt_o=0, wght_loaded_o=0, pxl_ready_o=0, wght_ready_o=1.
- Reset asserted mid-load or mid-output discards everything; no partial bank survives.
- Pixel-to-output latency is 1 cycle; one block per cycle sustained while out_ready_i=1.
- First load: last beat on edge N, swap on edge N+1, pxl_ready_o=1 from cycle N+1; wght_loaded_o rises at edge N+1 and stays high until reset.
- Reload while output is stalled: remains in PEND until out_ready_i=1; swap and handshake share that edge.
- wght_valid_i is ignored in PEND; beat_cnt does not advance.

## Structure
- Package conv_router_pkg: default parameters, the FSM state enum, and the window-index function (r,c,i)->pixel index.
- Sub-module conv_wght_bank: double-buffered bank with beat counter, bank_sel and swap input. The top level holds the FSM, slicer and output register.

## Test plan
- Reset, load 30 beats with weight = beat*5+c -> wght_loaded_o=1 two edges after reset release+30; wght_o[2][3][7] = 11*... (f=2, r=1, c=2 → beat 11, value 57).
- Pixel block where rows[r][p]=r*16+p, STRIDE=1 -> pxl_win_o[0][3][6] = rows[1][4] = 0x14 for all f, one cycle later.
- STRIDE=2, NUM_PXL_ROW=12 -> pxl_win_o[x][3][0] = rows[0][6].
- Hold out_ready_i=0, complete reload -> state PEND, pxl_ready_o=0, wght_o unchanged; raise out_ready_i -> swap on that edge, win_cnt_o+1.
- Simultaneous last weight beat and pixel accept -> that block's wght_o is the old bank; the next block is also old until the swap edge.
- 65 536 blocks with out_ready_i=1 -> win_cnt_o wraps to 0; assert rst_i mid-stream -> all outputs at reset values asynchronously.
